// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, RUN, HALTED, FAULT)
//   INSTR_W       : instruction word width
//   ADDR_W_DEF    : default PC / address width
//   ALIGN_MASK    : low address bits that must be zero for a word fetch
//   is_misaligned : true when a byte address is not word aligned
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W_DEF = 32;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Bundle between the fetch stage and its neighbours (instruction ROM,
// decode stage, status observers).
//   slave  : the fetch stage itself
//   master : the environment (ROM returns instr_rdata, ID drives
//            stall/redirect/halt and consumes the IF/ID register)
//
// Handshake: the IF/ID register transfers to decode on every rising edge
// where if_id_valid=1 and stall=0. stall is the inverse of a ready signal;
// while it is high the fetch stage holds if_id_* and the PC unchanged. The
// ROM leg has no handshake: instr_rdata must answer instr_addr in the same
// cycle. dbg_state mirrors the fetch FSM state for observation only.
interface mips_fetch_stage_if;
  import mips_pkg::*;

  logic                stall;
  logic                redirect_valid;
  logic [31:0]         redirect_target;
  logic                halt_req;
  logic [31:0]         instr_addr;
  logic [INSTR_W-1:0]  instr_rdata;
  logic                if_id_valid;
  logic [INSTR_W-1:0]  if_id_instr;
  logic [31:0]         if_id_pc;
  logic [31:0]         if_id_pc_plus4;
  logic                active;
  logic                fault;
  logic [31:0]         fault_addr;
  logic [31:0]         fetch_count;
  fetch_state_t        dbg_state;

  modport slave (
    input  stall, redirect_valid, redirect_target, halt_req, instr_rdata,
    output instr_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           active, fault, fault_addr, fetch_count, dbg_state
  );

  modport master (
    output stall, redirect_valid, redirect_target, halt_req, instr_rdata,
    input  instr_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
           active, fault, fault_addr, fetch_count, dbg_state
  );

endinterface

// File: rtl/mips_pc_reg.sv
// Program counter with next-PC selection and a one-entry pending redirect.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   advance_i           : a fetch happens this cycle; load the next PC
//   capture_i           : stalled in RUN; remember a redirect for later
//   redirect_valid_i    : redirect resolved in decode this cycle
//   redirect_target_i   : redirect destination
//   pc_o, pc_plus4_o    : current PC and its sequential successor
module mips_pc_reg #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance_i,
  input  logic              capture_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [ADDR_W-1:0] pc_plus4;

  // Wraps modulo 2^ADDR_W by construction.
  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (advance_i) begin
      // A fresh redirect beats one remembered from a stall.
      if (redirect_valid_i)  pc_d = redirect_target_i;
      else if (pend_valid_q) pc_d = pend_target_q;
      else                   pc_d = pc_plus4;
      pend_valid_d = 1'b0;
    end else if (capture_i && redirect_valid_i) begin
      // Newest redirect wins if decode re-resolves during a long stall.
      pend_valid_d  = 1'b1;
      pend_target_d = redirect_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage of the Harvard MIPS core.
// Drives the PC onto the combinational instruction ROM, captures the word
// into the IF/ID register, and handles stall, delay-slot redirects, halt
// and misaligned-target faults.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mips_fetch_stage_if.slave (ROM, decode and status signals)
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W       = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                reset,
  mips_fetch_stage_if.slave   bus
);

  fetch_state_t       state_q;
  logic               if_id_valid_q;
  logic [INSTR_W-1:0] if_id_instr_q;
  logic [ADDR_W-1:0]  if_id_pc_q;
  logic [ADDR_W-1:0]  if_id_pc_plus4_q;
  logic               active_q;
  logic               fault_q;
  logic [ADDR_W-1:0]  fault_addr_q;
  logic [31:0]        fetch_count_q;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus4;
  logic               bad_redirect;
  logic               keep_running;
  logic               advance;
  logic               capture;

  // A misaligned target faults whether or not decode is stalling us, and
  // it takes precedence over a simultaneous halt request.
  assign bad_redirect = bus.redirect_valid && is_misaligned(bus.redirect_target[1:0]);
  assign keep_running = (state_q == RUN) && !bad_redirect && !bus.halt_req;
  assign advance      = keep_running && !bus.stall;
  assign capture      = keep_running && bus.stall;

  mips_pc_reg #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk               (clk),
    .reset             (reset),
    .advance_i         (advance),
    .capture_i         (capture),
    .redirect_valid_i  (bus.redirect_valid),
    .redirect_target_i (bus.redirect_target),
    .pc_o              (pc),
    .pc_plus4_o        (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      if_id_valid_q    <= 1'b0;
      if_id_instr_q    <= '0;
      if_id_pc_q       <= '0;
      if_id_pc_plus4_q <= '0;
      active_q         <= 1'b1;
      fault_q          <= 1'b0;
      fault_addr_q     <= '0;
      fetch_count_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q       <= RUN;
          if_id_valid_q <= 1'b0;
        end
        RUN: begin
          if (bad_redirect) begin
            state_q       <= FAULT;
            fault_q       <= 1'b1;
            fault_addr_q  <= bus.redirect_target;
            if_id_valid_q <= 1'b0;
            active_q      <= 1'b0;
          end else if (bus.halt_req) begin
            state_q       <= HALTED;
            if_id_valid_q <= 1'b0;
            active_q      <= 1'b0;
          end else if (!bus.stall) begin
            // The word fetched alongside a redirect is the delay slot and
            // is delivered like any other instruction.
            if_id_valid_q    <= 1'b1;
            if_id_instr_q    <= bus.instr_rdata;
            if_id_pc_q       <= pc;
            if_id_pc_plus4_q <= pc_plus4;
            fetch_count_q    <= fetch_count_q + 32'd1;
          end
        end
        HALTED, FAULT: begin
          if_id_valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.instr_addr     = pc;
  assign bus.if_id_valid    = if_id_valid_q;
  assign bus.if_id_instr    = if_id_instr_q;
  assign bus.if_id_pc       = if_id_pc_q;
  assign bus.if_id_pc_plus4 = if_id_pc_plus4_q;
  assign bus.active         = active_q;
  assign bus.fault          = fault_q;
  assign bus.fault_addr     = fault_addr_q;
  assign bus.fetch_count    = fetch_count_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
module tb_mips_fetch_stage;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mips_fetch_stage_if fa ();
  mips_fetch_stage_if fb ();

  mips_fetch_stage dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (fa.slave)
  );

  mips_fetch_stage #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (fb.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout reached without summary");
    $fatal(1, "timeout");
  end

  // ---------------- instruction ROM ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hAC41_000A;
      32'h0000_0004: return 32'h8C43_000A;
      default:       return a ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign fa.instr_rdata = rom_word(fa.instr_addr);
  assign fb.instr_rdata = rom_word(fb.instr_addr);

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fa.stall = 0; fa.redirect_valid = 0; fa.redirect_target = 0; fa.halt_req = 0;
    fb.stall = 0; fb.redirect_valid = 0; fb.redirect_target = 0; fb.halt_req = 0;
  endtask

  // ---------------- reference model (dut_a) ----------------
  // Mode: 0 idle, 1 running, 2 halted, 3 faulted.
  int          m_mode;
  logic [31:0] m_pc, m_pend_t, m_instr, m_ipc, m_faddr, m_count;
  logic        m_pend, m_valid, m_fault;

  task automatic model_step(input logic rst, input logic st, input logic rv,
                            input logic [31:0] rt, input logic hr);
    if (rst) begin
      m_mode = 0; m_pc = 0; m_pend = 0; m_pend_t = 0; m_valid = 0;
      m_instr = 0; m_ipc = 0; m_fault = 0; m_faddr = 0; m_count = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_valid = 0;
    end else if (m_mode == 1) begin
      if (rv && (rt % 4 != 0)) begin
        m_mode = 3; m_fault = 1; m_faddr = rt; m_valid = 0;
      end else if (hr) begin
        m_mode = 2; m_valid = 0;
      end else if (!st) begin
        m_instr = rom_word(m_pc); m_ipc = m_pc; m_valid = 1; m_count = m_count + 1;
        if (rv)          m_pc = rt;
        else if (m_pend) m_pc = m_pend_t;
        else             m_pc = m_pc + 4;
        m_pend = 0;
      end else if (rv) begin
        m_pend = 1; m_pend_t = rt;
      end
    end else begin
      m_valid = 0;
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick(); tick();
    checks++; if (fa.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", fa.if_id_valid); end
    checks++; if ({fa.if_id_instr, fa.if_id_pc, fa.if_id_pc_plus4} !== 96'd0) begin errors++; $display("FAIL reset_ifid got=%h %h %h exp=0", fa.if_id_instr, fa.if_id_pc, fa.if_id_pc_plus4); end
    checks++; if ({fa.fault, fa.fault_addr, fa.fetch_count} !== 65'd0) begin errors++; $display("FAIL reset_fault_cnt got=%0h %h %0d exp=0", fa.fault, fa.fault_addr, fa.fetch_count); end
    checks++; if (fa.instr_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", fa.instr_addr); end
    checks++; if (fa.dbg_state !== IDLE || fa.active !== 1'b1) begin errors++; $display("FAIL reset_state got=%0d act=%0h exp=IDLE act=1", fa.dbg_state, fa.active); end
    checks++; if (fb.instr_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_vector_b got=%h exp=fffffffc", fb.instr_addr); end
  endtask

  task automatic test_basic_fetch();
    reset = 0;
    tick();
    checks++; if (fa.if_id_valid !== 1'b0 || fa.instr_addr !== 32'h0) begin errors++; $display("FAIL idle_cycle got valid=%0h pc=%h exp valid=0 pc=0", fa.if_id_valid, fa.instr_addr); end
    tick();
    checks++; if ({fa.if_id_valid, fa.if_id_instr, fa.if_id_pc, fa.if_id_pc_plus4} !== {1'b1, 32'hAC41_000A, 32'h0, 32'h4})
      begin errors++; $display("FAIL fetch0 got=%0h %h %h %h exp=1 ac41000a 0 4", fa.if_id_valid, fa.if_id_instr, fa.if_id_pc, fa.if_id_pc_plus4); end
    tick();
    checks++; if ({fa.if_id_instr, fa.if_id_pc, fa.if_id_pc_plus4} !== {32'h8C43_000A, 32'h4, 32'h8})
      begin errors++; $display("FAIL fetch4 got=%h %h %h exp=8c43000a 4 8", fa.if_id_instr, fa.if_id_pc, fa.if_id_pc_plus4); end
    checks++; if (fa.fetch_count !== 32'd2) begin errors++; $display("FAIL fetch_count2 got=%0d exp=2", fa.fetch_count); end
  endtask

  task automatic test_stall_pending();
    fa.stall = 1;
    for (int c = 0; c < 3; c++) begin
      fa.redirect_valid = (c == 1);
      fa.redirect_target = 32'h40;
      tick();
      checks++; if ({fa.if_id_pc, fa.instr_addr, fa.fetch_count} !== {32'h4, 32'h8, 32'd2})
        begin errors++; $display("FAIL stall_freeze%0d got ifpc=%h pc=%h cnt=%0d exp 4 8 2", c, fa.if_id_pc, fa.instr_addr, fa.fetch_count); end
    end
    fa.redirect_valid = 0;
    fa.stall = 0;
    tick();
    checks++; if ({fa.if_id_pc, fa.if_id_instr, fa.instr_addr} !== {32'h8, rom_word(32'h8), 32'h40})
      begin errors++; $display("FAIL delay_slot got ifpc=%h instr=%h pc=%h exp 8 %h 40", fa.if_id_pc, fa.if_id_instr, fa.instr_addr, rom_word(32'h8)); end
    tick();
    checks++; if ({fa.if_id_pc, fa.instr_addr} !== {32'h40, 32'h44})
      begin errors++; $display("FAIL pending_target got ifpc=%h pc=%h exp 40 44", fa.if_id_pc, fa.instr_addr); end
  endtask

  task automatic test_redirect_over_pending();
    fa.stall = 1; fa.redirect_valid = 1; fa.redirect_target = 32'h40;
    tick();
    fa.stall = 0; fa.redirect_target = 32'h80;
    tick();
    fa.redirect_valid = 0;
    checks++; if ({fa.if_id_pc, fa.instr_addr} !== {32'h44, 32'h80})
      begin errors++; $display("FAIL redirect_beats_pending got ifpc=%h pc=%h exp 44 80", fa.if_id_pc, fa.instr_addr); end
    tick();
    checks++; if ({fa.if_id_pc, fa.instr_addr, fa.fetch_count} !== {32'h80, 32'h84, 32'd6})
      begin errors++; $display("FAIL pending_cleared got ifpc=%h pc=%h cnt=%0d exp 80 84 6", fa.if_id_pc, fa.instr_addr, fa.fetch_count); end
  endtask

  task automatic test_misaligned();
    fa.redirect_valid = 1; fa.redirect_target = 32'h42; fa.halt_req = 1;
    tick();
    fa.redirect_valid = 0; fa.halt_req = 0;
    checks++; if ({fa.fault, fa.fault_addr, fa.active, fa.if_id_valid} !== {1'b1, 32'h42, 1'b0, 1'b0})
      begin errors++; $display("FAIL misalign got fault=%0h addr=%h act=%0h v=%0h exp 1 42 0 0", fa.fault, fa.fault_addr, fa.active, fa.if_id_valid); end
    checks++; if (fa.dbg_state !== FAULT || fa.instr_addr !== 32'h84) begin errors++; $display("FAIL misalign_state got st=%0d pc=%h exp FAULT 84", fa.dbg_state, fa.instr_addr); end
    for (int c = 0; c < 6; c++) begin
      fa.stall = 1'($urandom_range(0, 1)); fa.redirect_valid = 1'($urandom_range(0, 1));
      fa.redirect_target = 32'($urandom_range(0, 255)) << 2; fa.halt_req = 1'($urandom_range(0, 1));
      tick();
    end
    idle_inputs();
    checks++; if ({fa.dbg_state, fa.fault_addr, fa.fetch_count, fa.instr_addr, fa.if_id_valid} !== {FAULT, 32'h42, 32'd6, 32'h84, 1'b0})
      begin errors++; $display("FAIL fault_sticky got st=%0d addr=%h cnt=%0d pc=%h v=%0h", fa.dbg_state, fa.fault_addr, fa.fetch_count, fa.instr_addr, fa.if_id_valid); end
    reset = 1;
    tick();
    reset = 0;
    checks++; if ({fa.instr_addr, fa.fault, fa.fault_addr, fa.active} !== {32'h0, 1'b0, 32'h0, 1'b1})
      begin errors++; $display("FAIL fault_reset got pc=%h fault=%0h addr=%h act=%0h exp 0 0 0 1", fa.instr_addr, fa.fault, fa.fault_addr, fa.active); end
  endtask

  task automatic test_halt_wrap();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    tick();
    checks++; if (fb.if_id_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle got=%0h exp=0", fb.if_id_valid); end
    tick();
    checks++; if ({fb.if_id_pc, fb.if_id_pc_plus4, fb.instr_addr, fb.fault} !== {32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0})
      begin errors++; $display("FAIL wrap_fetch got ifpc=%h p4=%h pc=%h fault=%0h exp fffffffc 0 0 0", fb.if_id_pc, fb.if_id_pc_plus4, fb.instr_addr, fb.fault); end
    tick();
    checks++; if ({fb.if_id_pc, fb.if_id_instr, fb.instr_addr} !== {32'h0, 32'hAC41_000A, 32'h4})
      begin errors++; $display("FAIL wrap_next got ifpc=%h instr=%h pc=%h exp 0 ac41000a 4", fb.if_id_pc, fb.if_id_instr, fb.instr_addr); end
    fb.halt_req = 1;
    tick();
    fb.halt_req = 0;
    checks++; if ({fb.active, fb.if_id_valid, fb.fetch_count, fb.dbg_state} !== {1'b0, 1'b0, 32'd2, HALTED})
      begin errors++; $display("FAIL halt got act=%0h v=%0h cnt=%0d st=%0d exp 0 0 2 HALTED", fb.active, fb.if_id_valid, fb.fetch_count, fb.dbg_state); end
    repeat (4) tick();
    checks++; if ({fb.fetch_count, fb.instr_addr, fb.if_id_pc, fb.if_id_valid} !== {32'd2, 32'h4, 32'h0, 1'b0})
      begin errors++; $display("FAIL halt_hold got cnt=%0d pc=%h ifpc=%h v=%0h exp 2 4 0 0", fb.fetch_count, fb.instr_addr, fb.if_id_pc, fb.if_id_valid); end
  endtask

  task automatic test_reset_mid_stall();
    fa.stall = 1; fa.redirect_valid = 1; fa.redirect_target = 32'h100;
    tick();
    fa.redirect_valid = 0;
    reset = 1;
    tick();
    checks++; if ({fa.if_id_valid, fa.if_id_pc, fa.fetch_count, fa.instr_addr, fa.dbg_state} !== {1'b0, 32'h0, 32'd0, 32'h0, IDLE})
      begin errors++; $display("FAIL reset_mid_stall got v=%0h ifpc=%h cnt=%0d pc=%h st=%0d", fa.if_id_valid, fa.if_id_pc, fa.fetch_count, fa.instr_addr, fa.dbg_state); end
    reset = 0; fa.stall = 0;
    tick(); tick();
    checks++; if ({fa.if_id_pc, fa.instr_addr} !== {32'h0, 32'h4})
      begin errors++; $display("FAIL pending_discarded got ifpc=%h pc=%h exp 0 4", fa.if_id_pc, fa.instr_addr); end
  endtask

  task automatic test_random();
    logic        r_rst, r_st, r_rv, r_hr;
    logic [31:0] r_rt;
    idle_inputs();
    reset = 1;
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int c = 0; c < 600; c++) begin
      r_rst = (m_mode >= 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 9) < 3);
      r_rv  = ($urandom_range(0, 5) == 0);
      r_rt  = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 39) == 0) r_rt[1:0] = 2'($urandom_range(1, 3));
      r_hr  = ($urandom_range(0, 79) == 0);
      reset = r_rst; fa.stall = r_st; fa.redirect_valid = r_rv;
      fa.redirect_target = r_rt; fa.halt_req = r_hr;
      model_step(r_rst, r_st, r_rv, r_rt, r_hr);
      tick();
      checks++;
      if ({fa.instr_addr, fa.if_id_valid, fa.fault, fa.fault_addr, fa.fetch_count, fa.active} !==
          {m_pc, m_valid, m_fault, m_faddr, m_count, (m_mode < 2)}) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d got pc=%h v=%0h f=%0h fa=%h cnt=%0d act=%0h exp pc=%h v=%0h f=%0h fa=%h cnt=%0d act=%0h",
                 c, fa.instr_addr, fa.if_id_valid, fa.fault, fa.fault_addr, fa.fetch_count, fa.active,
                 m_pc, m_valid, m_fault, m_faddr, m_count, (m_mode < 2));
      end
      checks++;
      if ({fa.if_id_instr, fa.if_id_pc, fa.if_id_pc_plus4} !== {m_instr, m_ipc, m_ipc + 32'd4} && m_count != 0) begin
        errors++;
        $display("FAIL rand_ifid c=%0d got %h %h %h exp %h %h %h", c, fa.if_id_instr, fa.if_id_pc,
                 fa.if_id_pc_plus4, m_instr, m_ipc, m_ipc + 32'd4);
      end
    end
    reset = 0;
    idle_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_basic_fetch();
    test_stall_pending();
    test_redirect_over_pending();
    test_misaligned();
    test_halt_wrap();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Instruction-fetch stage of the Harvard MIPS core.
- Owns the program counter and drives the byte address into the combinational instruction ROM.
- Captures the 32-bit big-endian word returned in the same cycle into an IF/ID pipeline register for the decoder.
- Handles stalls, decode-stage redirects (branch/jump with MIPS delay-slot semantics), halt and misaligned-target faults.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
ADDR_W, 32, PC / address width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  decode back-pressure; hold PC and IF/ID register
redirect_valid  input  1  branch/jump resolved in ID this cycle
redirect_target  input  32  new PC for redirect
halt_req  input  1  stop fetching (from ID on halt condition)
instr_addr  output  32  byte address to instruction ROM (= pc, combinational)
instr_rdata  input  32  ROM read data for instr_addr, same cycle
if_id_valid  output  1  IF/ID register holds a real instruction
if_id_instr  output  32  fetched instruction word
if_id_pc  output  32  address of if_id_instr
if_id_pc_plus4  output  32  if_id_pc + 4 (mod 2^32)
active  output  1  high in IDLE/RUN; low in HALTED/FAULT
fault  output  1  sticky misaligned-target flag
fault_addr  output  32  offending redirect target
fetch_count  output  32  number of instructions accepted into IF/ID

Behaviour:
Reset (synchronous; reset has priority over all other inputs, including mid-stall or mid-fault):
- pc=RESET_VECTOR.
- state=IDLE.
- if_id_valid=0; if_id_instr, if_id_pc, if_id_pc_plus4 = 0.
- fault=0; fault_addr=0; fetch_count=0.
- pending_valid=0.

States: IDLE, RUN, HALTED, FAULT.
- IDLE -> RUN unconditionally after 1 cycle. if_id_valid=0; pc holds.
- RUN, stall=0 (fetch step):
  - if_id_instr<=instr_rdata; if_id_pc<=pc; if_id_pc_plus4<=pc+4; if_id_valid<=1; fetch_count++ (wraps).
  - next pc priority: redirect_valid ? redirect_target : pending_valid ? pending_target : pc+4. Clear pending_valid.
  - Latency: the instruction at pc appears in IF/ID the next cycle.
- RUN, stall=1:
  - pc, IF/ID register and fetch_count all hold.
  - if redirect_valid: pending_valid<=1, pending_target<=redirect_target. A newer redirect overwrites an older pending one.
- Delay slot: the word fetched in the same cycle a redirect is presented is kept valid (it is the delay slot). The redirect target is the next fetch.
- Misaligned target: redirect_target[1:0]!=0 while redirect_valid in RUN (stalled or not):
  - -> FAULT; fault<=1; fault_addr<=redirect_target; if_id_valid<=0; pc holds.
  - Misalignment is checked before halt_req.
- halt_req in RUN (no fault): -> HALTED; if_id_valid<=0 next cycle; pc holds; no further fetches.
- HALTED and FAULT are terminal until reset. All outputs hold except if_id_valid=0.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No fault is raised on wrap.
- instr_addr is always pc, including in IDLE/HALTED/FAULT.

Decomposition:
Shared package mips_pkg:
- fetch_state_t enum {IDLE, RUN, HALTED, FAULT}.
- INSTR_W=32.
- Byte-alignment mask constant.
Optional sub-module mips_pc_reg: PC register plus next-PC mux including pending-redirect storage. The remainder (FSM, IF/ID register, counters) stays in mips_fetch_stage.

Test Plan:
1. Basic fetch. Stimulus: ROM with word0=32'hAC41000A, word4=32'h8C43000A; release reset; no stall.
   Required: IDLE for 1 cycle with valid=0. Then IF/ID={AC41000A, pc 0, pc+4 4}, then {8C43000A, pc 4}. fetch_count=2.
2. Stall with pending redirect. Stimulus: at pc=8, stall=1 for 3 cycles, redirect_valid pulsed on cycle 2 with target 32'h40.
   Required: IF/ID and pc frozen while stalled. First fetch after release is from 8 (delay slot), next from 32'h40.
3. Simultaneous redirect and pending. Stimulus: pending target 32'h40 set, then stall=0 with redirect_valid=1, target 32'h80.
   Required: next pc=32'h80; pending cleared.
4. Misaligned redirect. Stimulus: redirect_target=32'h42.
   Required: fault=1, fault_addr=32'h42, active=0, if_id_valid=0. State stays FAULT until reset; reset returns pc to 0 and clears fault.
5. Halt and wrap. Stimulus: reset with RESET_VECTOR=32'hFFFF_FFFC, run 2 cycles, then assert halt_req.
   Required: pcs fetched are FFFF_FFFC then 0000_0000, with if_id_pc_plus4=0 on the first. After halt, active=0 and fetch_count frozen at 2.
6. Reset mid-stall. Stimulus: assert reset while stall=1 and a pending redirect exists.
   Required: all outputs return to reset values next cycle; the pending redirect is discarded.
